fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined datapath. Directly upstream of the IF|ID boundary.
- Owns the PC register and drives the instruction-cache request (imemREN/imemaddr/ihit).
- Produces the registered IF|ID bundle (ifid_t: imemload, pc_plus).
- Absorbs hazard-unit stalls with a one-entry hold buffer, takes branch/jump redirects resolved downstream, and stops fetching on halt.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types used by the fetch stage and the IF|ID boundary.
package fetch_stage_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // IF|ID pipeline register payload
  typedef struct packed {
    word_t imemload;
    word_t pc_plus;
  } ifid_t;

  // Fetch control state
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache reads, fills the IF|ID
// register, parks one instruction in a hold buffer while the hazard unit
// stalls, and follows downstream redirects and halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output ifid_t       ifid,
  output logic        ifid_valid,
  output logic [31:0] pc
);

  fetch_state_t state;
  ifid_t        holdBuf;
  word_t        pcPlus4;
  word_t        redirectTarget;

  // Sequential address arithmetic; wraps naturally at 2^32
  assign pcPlus4        = pc + 32'd4;
  assign redirectTarget = redirect_pc & ~32'h3;

  // Request only while running, and never while reset is held
  assign imemREN  = (state == RUN) & nRST;
  assign imemaddr = {pc[31:2], 2'b00};

  // Fetch control: halt > redirect > stall > ihit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      ifid       <= '0;
      ifid_valid <= 1'b0;
      holdBuf    <= '0;
    end else if (halt) begin
      // Terminal: drop everything in flight, freeze the PC
      state      <= HALTED;
      ifid       <= '0;
      ifid_valid <= 1'b0;
      holdBuf    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            // Coincident hit belongs to the wrong path and is dropped
            pc         <= redirectTarget;
            ifid       <= '0;
            ifid_valid <= 1'b0;
            holdBuf    <= '0;
          end else if (ihit && !stall) begin
            ifid       <= '{imemload: imemload, pc_plus: pcPlus4};
            ifid_valid <= 1'b1;
            pc         <= pcPlus4;
          end else if (ihit && stall) begin
            // IF|ID is frozen, so park the fetched word until stall drops
            holdBuf <= '{imemload: imemload, pc_plus: pcPlus4};
            pc      <= pcPlus4;
            state   <= HOLD;
          end else if (!ihit && !stall) begin
            // Miss: pass a bubble (all-zero word is a nop)
            ifid       <= '0;
            ifid_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc         <= redirectTarget;
            ifid       <= '0;
            ifid_valid <= 1'b0;
            holdBuf    <= '0;
            state      <= RUN;
          end else if (!stall) begin
            ifid       <= holdBuf;
            ifid_valid <= 1'b1;
            state      <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  ifid_t       ifid;
  logic        ifid_valid;
  logic [31:0] pc;

  int testsRun;
  int testsFailed;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .ifid       (ifid),
    .ifid_valid (ifid_valid),
    .pc         (pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison and report it if it does not match
  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Check the full registered state after a cycle
  task automatic checkStage(input string tag, input logic [31:0] expWord,
                            input logic [31:0] expPlus, input logic expValid,
                            input logic [31:0] expPc);
    checkEq({tag, ".ifid"}, 64'(ifid), {expWord, expPlus});
    checkEq({tag, ".valid"}, 64'(ifid_valid), 64'(expValid));
    checkEq({tag, ".pc"}, 64'(pc), 64'(expPc));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    nRST        = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;

    // Reset state
    #2;
    checkEq("rst.ren", 64'(imemREN), 64'(1'b0));
    checkStage("rst", 32'h0, 32'h0, 1'b0, 32'h0);

    // Release reset with a constant hit
    ihit     = 1'b1;
    imemload = 32'h2001_0005;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkEq("c1.ren", 64'(imemREN), 64'(1'b1));
    checkEq("c1.addr", 64'(imemaddr), 64'(32'h0));
    cyc();
    checkStage("c2", 32'h2001_0005, 32'h4, 1'b1, 32'h4);

    imemload = 32'h1111_0001;
    cyc();
    checkStage("seq", 32'h1111_0001, 32'h8, 1'b1, 32'h8);

    // Three-cycle miss at pc=8
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checkStage($sformatf("miss%0d", i), 32'h0, 32'h0, 1'b0, 32'h8);
      checkEq($sformatf("miss%0d.addr", i), 64'(imemaddr), 64'(32'h8));
      checkEq($sformatf("miss%0d.ren", i), 64'(imemREN), 64'(1'b1));
    end

    ihit     = 1'b1;
    imemload = 32'h2222_0002;
    cyc();
    checkStage("resume", 32'h2222_0002, 32'hC, 1'b1, 32'hC);
    imemload = 32'h3333_0003;
    cyc();
    checkStage("pc10", 32'h3333_0003, 32'h10, 1'b1, 32'h10);

    // Hit under stall at pc=0x10 goes to the hold buffer
    stall    = 1'b1;
    imemload = 32'h4444_0004;
    cyc();
    checkStage("hold0", 32'h3333_0003, 32'h10, 1'b1, 32'h14);
    checkEq("hold0.ren", 64'(imemREN), 64'(1'b0));
    imemload = 32'hDEAD_BEEF;
    for (int i = 1; i < 3; i++) begin
      cyc();
      checkStage($sformatf("hold%0d", i), 32'h3333_0003, 32'h10, 1'b1, 32'h14);
      checkEq($sformatf("hold%0d.ren", i), 64'(imemREN), 64'(1'b0));
    end
    stall = 1'b0;
    ihit  = 1'b0;
    cyc();
    checkStage("unhold", 32'h4444_0004, 32'h14, 1'b1, 32'h14);
    checkEq("unhold.ren", 64'(imemREN), 64'(1'b1));
    checkEq("unhold.addr", 64'(imemaddr), 64'(32'h14));
    ihit     = 1'b1;
    imemload = 32'h5555_0005;
    cyc();
    checkStage("after", 32'h5555_0005, 32'h18, 1'b1, 32'h18);

    // Redirect while holding; held word and coincident hit are discarded
    stall    = 1'b1;
    imemload = 32'h6666_0006;
    cyc();
    checkStage("hold2", 32'h5555_0005, 32'h18, 1'b1, 32'h1C);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    imemload    = 32'h7777_0007;
    cyc();
    checkStage("redir", 32'h0, 32'h0, 1'b0, 32'h100);
    checkEq("redir.ren", 64'(imemREN), 64'(1'b1));
    redirect = 1'b0;
    stall    = 1'b0;
    imemload = 32'h8888_0008;
    cyc();
    checkStage("redir1", 32'h8888_0008, 32'h104, 1'b1, 32'h104);

    // Redirect in RUN to the top of the address space, then wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    imemload    = 32'h9999_0009;
    cyc();
    checkStage("redirTop", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    checkEq("redirTop.addr", 64'(imemaddr), 64'(32'hFFFF_FFFC));
    redirect = 1'b0;
    imemload = 32'hAAAA_000A;
    cyc();
    checkStage("wrap", 32'hAAAA_000A, 32'h0, 1'b1, 32'h0);
    imemload = 32'hBBBB_000B;
    cyc();
    checkStage("preHalt", 32'hBBBB_000B, 32'h4, 1'b1, 32'h4);

    // Halt beats redirect and hit; stays halted
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc();
    checkStage("halt", 32'h0, 32'h0, 1'b0, 32'h4);
    checkEq("halt.ren", 64'(imemREN), 64'(1'b0));
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checkStage($sformatf("halted%0d", i), 32'h0, 32'h0, 1'b0, 32'h4);
      checkEq($sformatf("halted%0d.ren", i), 64'(imemREN), 64'(1'b0));
    end
    redirect = 1'b0;

    // Reset pulse restarts fetch at PC_INIT
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checkStage("rst2", 32'h0, 32'h0, 1'b0, 32'h0);
    checkEq("rst2.ren", 64'(imemREN), 64'(1'b0));
    @(negedge CLK);
    nRST     = 1'b1;
    imemload = 32'hCCCC_000C;
    #1;
    checkEq("rst2.ren1", 64'(imemREN), 64'(1'b1));
    cyc();
    checkStage("restart", 32'hCCCC_000C, 32'h4, 1'b1, 32'h4);

    // Reset in the middle of HOLD clears the buffered word
    stall    = 1'b1;
    imemload = 32'hDDDD_000D;
    cyc();
    checkEq("hold3.ren", 64'(imemREN), 64'(1'b0));
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    nRST  = 1'b1;
    stall = 1'b0;
    ihit  = 1'b0;
    #1;
    checkEq("rstHold.ren", 64'(imemREN), 64'(1'b1));
    cyc();
    checkStage("rstHold", 32'h0, 32'h0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_fetch_stage
